// File: rtl/synth_pkg.sv
// Definitions shared by the voice allocator and the frequency-lookup/oscillator chain.
package synth_pkg;

    localparam int NUM_VOICES = 16;
    localparam int NOTE_W     = 7;
    localparam int IDX_W      = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice: held note, gate and a saturating age counter.
module voice_slot
    import synth_pkg::*;
#(
    parameter int AGE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NOTE_W-1:0] load_note,
    input  logic              retrig,
    input  logic              clear,
    input  logic              age_inc,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic [AGE_W-1:0]  age
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // load/retrig/clear are mutually exclusive per slot; age_inc only touches untargeted gated slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note <= '0;
            gate <= 1'b0;
            age  <= '0;
        end else if (load) begin
            note <= load_note;
            gate <= 1'b1;
            age  <= '0;
        end else if (retrig) begin
            age <= '0;
        end else if (clear) begin
            gate <= 1'b0;
        end else if (age_inc && gate && (age != AGE_MAX)) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan of the voice slots, then a one-cycle commit.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int AGE_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic                         all_off,
    output logic [NUM_VOICES*NOTE_W-1:0] notes,
    output logic [NUM_VOICES-1:0]        gates,
    output logic                         stolen,
    output logic [1:0]                   dbg_state,
    output logic [NUM_VOICES*AGE_W-1:0]  dbg_ages
);

    alloc_state_t state, state_nxt;

    logic [IDX_W-1:0]      scan_idx;
    logic                  ev_on_q;
    logic [NOTE_W-1:0]     ev_note_q;
    logic                  match_found, free_found;
    logic [IDX_W-1:0]      match_idx, free_idx, oldest_idx;
    logic [AGE_W-1:0]      oldest_age;
    logic [NUM_VOICES-1:0] off_mask;

    logic [NOTE_W-1:0]     v_note [NUM_VOICES];
    logic [AGE_W-1:0]      v_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] v_gate;

    logic [NUM_VOICES-1:0] slot_load, slot_retrig, slot_clear;
    logic                  slot_age_inc, steal;
    logic                  accept, do_all_off, scan_hit;

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready in IDLE and all_off is
    // low; the source holds ev_on/ev_note stable while ev_valid is high and ev_ready is low.
    assign accept     = (state == IDLE) && ev_ready && ev_valid && !all_off;
    assign do_all_off = (state == IDLE) && all_off;
    assign scan_hit   = v_gate[scan_idx] && (v_note[scan_idx] == ev_note_q);
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (scan_idx == IDX_W'(NUM_VOICES - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ev_ready is registered so it stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ev_ready <= 1'b0;
            stolen   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ev_ready <= (state_nxt == IDLE);
            stolen   <= steal;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_idx    <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            oldest_age  <= '0;
            off_mask    <= '0;
        end else if (accept) begin
            scan_idx    <= '0;
            ev_on_q     <= ev_on;
            ev_note_q   <= ev_note;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            oldest_age  <= '0;
            off_mask    <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + IDX_W'(1);
            if (scan_hit) begin
                off_mask[scan_idx] <= 1'b1;
                if (!match_found) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
            end
            if (!v_gate[scan_idx] && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (v_age[scan_idx] > oldest_age) begin
                oldest_idx <= scan_idx;
                oldest_age <= v_age[scan_idx];
            end
        end
    end

    always_comb begin
        slot_load    = '0;
        slot_retrig  = '0;
        slot_clear   = '0;
        slot_age_inc = 1'b0;
        steal        = 1'b0;
        if (state == COMMIT) begin
            if (ev_on_q) begin
                slot_age_inc = 1'b1;
                if (match_found) begin
                    slot_retrig[match_idx] = 1'b1;
                end else if (free_found) begin
                    slot_load[free_idx] = 1'b1;
                end else begin
                    slot_load[oldest_idx] = 1'b1;
                    steal                 = 1'b1;
                end
            end else begin
                slot_clear = off_mask;
            end
        end
        if (do_all_off) slot_clear = '1;
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (slot_load[i]),
            .load_note (ev_note_q),
            .retrig    (slot_retrig[i]),
            .clear     (slot_clear[i]),
            .age_inc   (slot_age_inc),
            .note      (v_note[i]),
            .gate      (v_gate[i]),
            .age       (v_age[i])
        );
        assign notes[i*NOTE_W +: NOTE_W]   = v_note[i];
        assign dbg_ages[i*AGE_W +: AGE_W] = v_age[i];
    end

    assign gates = v_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized scoreboard bench for voice_allocator against an array-based allocation model.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV        = NUM_VOICES;
    localparam int AGE_W     = 5;
    localparam int AGE_MAX   = (1 << AGE_W) - 1;
    localparam int NOTES_LSB = NV * AGE_W;
    localparam int GATES_LSB = NOTES_LSB + NV * NOTE_W;
    localparam int EXP_W     = GATES_LSB + NV + 1;
    localparam int LATENCY   = 18;

    // clock / reset / DUT
    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  ev_valid = 1'b0;
    logic                  ev_on = 1'b0;
    logic [NOTE_W-1:0]     ev_note = '0;
    logic                  all_off = 1'b0;
    logic                  ev_ready;
    logic [NV*NOTE_W-1:0]  notes;
    logic [NV-1:0]         gates;
    logic                  stolen;
    logic [1:0]            dbg_state;
    logic [NV*AGE_W-1:0]   dbg_ages;

    always #5 clk = ~clk;

    voice_allocator #(.AGE_W(AGE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_on     (ev_on),
        .ev_note   (ev_note),
        .all_off   (all_off),
        .notes     (notes),
        .gates     (gates),
        .stolen    (stolen),
        .dbg_state (dbg_state),
        .dbg_ages  (dbg_ages)
    );

    int checks = 0;
    int failures = 0;
    int exp_steals = 0;
    int stolen_seen = 0;
    int pending = 0;
    int lat_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // reference model: plain arrays, allocation rules applied directly
    int m_note[NV];
    int m_age[NV];
    bit m_gate[NV];

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0; m_age[i] = 0; m_gate[i] = 1'b0;
        end
    endfunction

    function automatic void model_all_off();
        for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
    endfunction

    function automatic bit model_event(input bit on, input int n);
        int tgt;
        bit stl;
        tgt = -1;
        stl = 1'b0;
        if (!on) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
            return 1'b0;
        end
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && !m_gate[i]) tgt = i;
        if (tgt < 0) begin
            tgt = 0;
            for (int i = 1; i < NV; i++)
                if (m_age[i] > m_age[tgt]) tgt = i;
            stl = 1'b1;
        end
        for (int i = 0; i < NV; i++)
            if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_note[tgt] = n;
        m_gate[tgt] = 1'b1;
        m_age[tgt]  = 0;
        return stl;
    endfunction

    function automatic logic [EXP_W-1:0] pack_model(input bit stl);
        logic [EXP_W-1:0] v;
        v = '0;
        for (int i = 0; i < NV; i++) begin
            v[i*AGE_W +: AGE_W]                = AGE_W'(m_age[i]);
            v[NOTES_LSB + i*NOTE_W +: NOTE_W] = NOTE_W'(m_note[i]);
            v[GATES_LSB + i]                   = m_gate[i];
        end
        v[EXP_W-1] = stl;
        return v;
    endfunction

    // driver tasks
    task automatic finish_accept(input bit on, input int n);
        bit stl;
        stl = model_event(on, n);
        if (stl) exp_steals++;
        exp_q.push_back(pack_model(stl));
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic send_event(input bit on, input int n);
        bit got;
        got = 1'b0;
        ev_on = on;
        ev_note = NOTE_W'(n);
        ev_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (ev_ready) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ready_timeout: actual=0 required=1");
            ev_valid = 1'b0;
        end else begin
            finish_accept(on, n);
        end
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (ev_ready) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL idle_timeout: actual=0 required=1");
        end
    endtask

    // monitor: pops one expected state per completed event
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (reset && stolen) stolen_seen++;
        if (!reset) begin
            pending = 0;
        end else begin
            if (pending != 0) begin
                lat_cnt++;
                if (ev_ready) begin
                    check("latency", 128'(lat_cnt), 128'(LATENCY));
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL scoreboard_empty: actual=0 required=1");
                    end else begin
                        e = exp_q.pop_front();
                        check("gates", 128'(gates), 128'(e[GATES_LSB +: NV]));
                        check("notes", 128'(notes), 128'(e[NOTES_LSB +: NV*NOTE_W]));
                        check("ages", 128'(dbg_ages), 128'(e[0 +: NV*AGE_W]));
                        check("stolen", 128'(stolen), 128'(e[EXP_W-1]));
                    end
                    pending = 0;
                end else if (lat_cnt == LATENCY - 1) begin
                    check("stolen_before_commit", 128'(stolen), 128'(0));
                end else if (lat_cnt > 40) begin
                    checks++; failures++;
                    $display("FAIL commit_timeout: actual=%0d required=%0d", lat_cnt, LATENCY);
                    pending = 0;
                end
            end
            if (pending == 0 && ev_valid && ev_ready && !all_off) begin
                pending = 1;
                lat_cnt = 0;
            end
        end
    end

    initial begin
        bit drained;
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_notes", 128'(notes), 128'(0));
        check("rst_gates", 128'(gates), 128'(0));
        check("rst_ready", 128'(ev_ready), 128'(0));
        check("rst_stolen", 128'(stolen), 128'(0));
        #2 reset = 1'b1;
        #1 check("ready_before_edge", 128'(ev_ready), 128'(0));
        @(negedge clk);
        check("ready_after_release", 128'(ev_ready), 128'(1));

        // note-on 60 interrupted by reset mid-scan
        @(posedge clk);
        #1 ev_valid = 1'b1; ev_on = 1'b1; ev_note = NOTE_W'(60);
        @(negedge clk);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midscan_rst_notes", 128'(notes), 128'(0));
        check("midscan_rst_gates", 128'(gates), 128'(0));
        check("midscan_rst_ready", 128'(ev_ready), 128'(0));
        check("midscan_rst_state", 128'(dbg_state), 128'(0));
        check("midscan_rst_ages", 128'(dbg_ages), 128'(0));
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("midscan_ready_after", 128'(ev_ready), 128'(1));
        check("midscan_gates_after", 128'(gates), 128'(0));
        @(posedge clk);
        #1;

        // chord, retrigger, note-off and reuse of the freed voice
        send_event(1'b1, 60);
        send_event(1'b1, 64);
        send_event(1'b1, 67);
        send_event(1'b1, 64);
        send_event(1'b0, 64);
        send_event(1'b1, 72);

        // all_off wins over a pending event, which is taken the next cycle
        wait_idle();
        @(posedge clk);
        #1 all_off = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = NOTE_W'(40);
        @(posedge clk);
        model_all_off();
        #1 all_off = 1'b0;
        @(negedge clk);
        check("all_off_gates", 128'(gates), 128'(0));
        check("all_off_ready", 128'(ev_ready), 128'(1));
        finish_accept(1'b1, 40);

        // fill every voice, the 17th note steals the oldest
        for (int n = 41; n <= 56; n++) send_event(1'b1, n);
        send_event(1'b0, 99);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                wait_idle();
                @(posedge clk);
                #1 all_off = 1'b1;
                @(posedge clk);
                model_all_off();
                #1 all_off = 1'b0;
                @(negedge clk);
                check("rand_all_off_gates", 128'(gates), 128'(0));
                @(posedge clk);
                #1;
            end else begin
                send_event(r >= 4, $urandom_range(40, 58));
            end
        end

        drained = 1'b0;
        for (int k = 0; k < 100 && !drained; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pending == 0) drained = 1'b1;
        end
        if (!drained) begin
            checks++; failures++;
            $display("FAIL drain_timeout: actual=%0d required=0", exp_q.size());
        end
        @(negedge clk);
        check("stolen_pulses", 128'(stolen_seen), 128'(exp_steals));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
